// File: rtl/cla_nibble_serial_adder_if.sv
// Operand/result handshake bundle for the nibble-serial CLA adder.
// The design side uses the slave modport; the producer/consumer side uses master.
`timescale 1ns/1ps
interface cla_nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/cla_nibble_serial_adder.sv
// Wide adder that pushes one nibble per clock through a single 4-bit CLA slice,
// LSB nibble first, registering the slice carry between steps.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready=1
// ADD   | one nibble per edge through the CLA slice
// DONE  | result held on the outputs until out_ready
`timescale 1ns/1ps
module cla_nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input logic                     clk,
    input logic                     rst_n,
    cla_nibble_serial_adder_if.slave bus
);
    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic [IDXW-1:0]  idx_q;

    logic [3:0] nib_a;
    logic [3:0] nib_b;
    logic [3:0] nib_sum;
    logic       nib_cout;
    logic [3:0] gen;
    logic [3:0] prop;
    logic [4:0] c;

    assign nib_a = a_q[4*idx_q +: 4];
    assign nib_b = b_q[4*idx_q +: 4];

    // Flat lookahead: every carry is a two-level function of g/p and the seed carry.
    always_comb begin
        gen  = nib_a & nib_b;
        prop = nib_a ^ nib_b;
        c[0] = carry_q;
        c[1] = gen[0] | (prop[0] & c[0]);
        c[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & c[0]);
        c[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
             | (prop[2] & prop[1] & prop[0] & c[0]);
        c[4] = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
             | (prop[3] & prop[2] & prop[1] & gen[0])
             | (prop[3] & prop[2] & prop[1] & prop[0] & c[0]);
        nib_sum  = prop ^ c[3:0];
        nib_cout = c[4];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_nxt = ADD;
                end
            end
            ADD: begin
                if (idx_q == LAST_IDX) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Carry is re-seeded from cin on every accept so nothing leaks between operations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        carry_q <= bus.cin;
                        idx_q   <= '0;
                    end
                end
                ADD: begin
                    sum_q[4*idx_q +: 4] <= nib_sum;
                    carry_q             <= nib_cout;
                    if (idx_q != LAST_IDX) begin
                        idx_q <= idx_q + IDXW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = (state == DONE) & carry_q;
    assign bus.ovf  = (state == DONE) & (a_q[WIDTH-1] == b_q[WIDTH-1])
                    & (sum_q[WIDTH-1] != a_q[WIDTH-1]);
endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// Bench for the nibble-serial CLA adder: directed corner cases then a randomized
// stream scored against plain integer arithmetic.
`timescale 1ns/1ps
module tb_cla_nibble_serial_adder;
    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    cla_nibble_serial_adder_if #(.WIDTH(W)) bus ();

    cla_nibble_serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    // Returns {ovf, cout, sum}; overflow is judged by the true signed result range.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin);
        int unsigned u;
        int          s;
        logic        v;
        u = 32'(a) + 32'(b) + 32'(cin);
        s = int'($signed(a)) + int'($signed(b)) + int'(cin);
        v = (s > 32767) || (s < -32768);
        return {v, u[W], u[W-1:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        logic [W+1:0] e;
        e = model(a, b, cin);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.a = a; bus.b = b; bus.cin = cin; bus.out_ready = 1'b0;
        chk("in_ready_idle", bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0; bus.a = 16'($urandom); bus.b = 16'($urandom); bus.cin = 1'($urandom);
        chk("in_ready_add", bus.in_ready, 0);
        for (int k = 1; k <= NIB; k++) begin
            @(negedge clk);
            chk("latency_out_valid", bus.out_valid, (k == NIB));
        end
        chk("op_sum", bus.sum, e[W-1:0]);
        chk("op_cout", bus.cout, e[W]);
        chk("op_ovf", bus.ovf, e[W+1]);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("op_back_to_idle", bus.in_ready, 1);
        chk("op_out_valid_low", bus.out_valid, 0);
    endtask

    initial begin
        logic [W+1:0] e;
        logic [W+1:0] q[$];
        int accepted;
        int retired;
        int cycles;

        n_assert = 0; n_fail = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.cin = 1'b0;

        // Reset then idle
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_sum", bus.sum, 0);
        chk("rst_cout", bus.cout, 0);
        chk("rst_ovf", bus.ovf, 0);

        // Full ripple and signed overflow cases
        run_op(16'hFFFF, 16'h0001, 1'b0);
        run_op(16'h7FFF, 16'h0000, 1'b1);
        run_op(16'h8000, 16'h8000, 1'b0);

        // Backpressure, with a competing in_valid held during DONE
        @(negedge clk);
        bus.in_valid = 1'b1; bus.a = 16'h1234; bus.b = 16'h4321; bus.cin = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (NIB) @(negedge clk);
        bus.in_valid = 1'b1; bus.a = 16'h1111; bus.b = 16'h2222; bus.cin = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk("bp_sum", bus.sum, 16'h5555);
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_in_ready", bus.in_ready, 0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("bp_release_in_ready", bus.in_ready, 1);
        chk("bp_release_out_valid", bus.out_valid, 0);
        chk("bp_no_accept_in_done", bus.sum, 16'h5555);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("bp_next_accept", bus.in_ready, 0);
        repeat (NIB) @(negedge clk);
        chk("bp_next_out_valid", bus.out_valid, 1);
        chk("bp_next_sum", bus.sum, 16'h3333);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;

        // Reset after the 2nd ADD edge
        @(negedge clk);
        bus.in_valid = 1'b1; bus.a = 16'h0F0F; bus.b = 16'h0F0F; bus.cin = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_sum", bus.sum, 0);
        chk("midrst_cout", bus.cout, 0);
        chk("midrst_ovf", bus.ovf, 0);
        chk("midrst_in_ready", bus.in_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op(16'h0001, 16'h0002, 1'b0);

        // Randomized stream with random backpressure
        accepted = 0; retired = 0; cycles = 0;
        while ((accepted < 200 || q.size() != 0) && cycles < 20000) begin
            @(negedge clk);
            cycles++;
            if (accepted < 200) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.a = 16'($urandom); bus.b = 16'($urandom); bus.cin = 1'($urandom);
            end else begin
                bus.in_valid = 1'b0;
            end
            bus.out_ready = 1'($urandom_range(0, 1));
            #1;
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model(bus.a, bus.b, bus.cin));
                accepted++;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("rand_out_valid_no_pending", bus.out_valid, 0);
                end else begin
                    e = q.pop_front();
                    chk("rand_sum", bus.sum, e[W-1:0]);
                    chk("rand_cout", bus.cout, e[W]);
                    chk("rand_ovf", bus.ovf, e[W+1]);
                    retired++;
                end
            end
        end
        chk("rand_retired_count", retired, 200);
        chk("rand_pending_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
